// File: rtl/pred_sched_pkg.sv
// Shared widths and record types for the predicate register block port scheduler.
package pred_sched_pkg;
    localparam int NUM_LANES = 8;
    localparam int NUM_WARPS = 16;
    localparam int NUM_PREGS = 32;
    localparam int LANE_W    = NUM_LANES;
    localparam int WARP_W    = $clog2(NUM_WARPS);
    localparam int ADDR_W    = $clog2(NUM_PREGS);
    localparam int ID_W      = 3;

    typedef struct packed {
        logic [WARP_W-1:0] warp;
        logic [ADDR_W-1:0] addr;
        logic [LANE_W-1:0] mask;
    } rd_req_t;

    // One cycle of work presented to the block; v0/v1 mark a live read on each port.
    typedef struct packed {
        logic [WARP_W-1:0] warp;
        logic [LANE_W-1:0] we;
        logic [ADDR_W-1:0] waddr;
        logic [LANE_W-1:0] wdata;
        logic              v0;
        logic              v1;
        logic [LANE_W-1:0] re0;
        logic [LANE_W-1:0] re1;
        logic [ADDR_W-1:0] ra0;
        logic [ADDR_W-1:0] ra1;
        logic [ID_W-1:0]   id0;
        logic [ID_W-1:0]   id1;
    } issue_t;
endpackage

// File: rtl/pred_rr_pick.sv
// Round-robin picker: returns the first and second set bits of req (one-hot each),
// scanning upward from ptr with wrap-around.
module pred_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     first,
    output logic [N-1:0]     second
);
    logic [PTR_W-1:0] idx;

    always_comb begin
        first  = '0;
        second = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                if (first == '0)
                    first[idx] = 1'b1;
                else if (second == '0)
                    second[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pred_port_scheduler.sv
// Shares the predicate register block (1 write, 2 read ports) between one writer and NUM_RD_REQ readers.
// Optional PRED_SCHED_FWD_EN: same-address read is granted with the write and sees the new lanes.
module pred_port_scheduler
    import pred_sched_pkg::*;
#(
    parameter int NUM_RD_REQ   = 4,
    parameter int STARVE_LIMIT = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [WARP_W-1:0]            wr_warp,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [LANE_W-1:0]            wr_mask,
    input  logic [LANE_W-1:0]            wr_data,
    input  logic [NUM_RD_REQ-1:0]        rd_valid,
    output logic [NUM_RD_REQ-1:0]        rd_ready,
    input  logic [NUM_RD_REQ*WARP_W-1:0] rd_warp,
    input  logic [NUM_RD_REQ*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD_REQ*LANE_W-1:0] rd_mask,
    output logic [NUM_RD_REQ-1:0]        rsp_valid,
    output logic [NUM_RD_REQ*LANE_W-1:0] rsp_data,
    output logic [WARP_W-1:0]            pr_warp_selector,
    output logic [LANE_W-1:0]            pr_write_en,
    output logic [ADDR_W-1:0]            pr_waddr,
    output logic [LANE_W-1:0]            pr_wdata,
    output logic [LANE_W-1:0]            pr_read_en_0,
    output logic [LANE_W-1:0]            pr_read_en_1,
    output logic [ADDR_W-1:0]            pr_raddr_0,
    output logic [ADDR_W-1:0]            pr_raddr_1,
    input  logic [LANE_W-1:0]            pr_rdata_0,
    input  logic [LANE_W-1:0]            pr_rdata_1
);
    localparam int         N     = NUM_RD_REQ;
    localparam int         PTR_W = $clog2(N);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    rd_req_t             req [N];
    issue_t              issue, issue_d;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_d;
    logic [3:0]          wait_cnt [N];
    logic [N-1:0]        starved, clash, elig, gnt_first, gnt_second, rd_grant;
    logic [N-1:0]        rsp_valid_d;
    logic [N*LANE_W-1:0] rsp_data_d;
    logic [PTR_W-1:0]    scan_idx, starve_idx, first_idx, gnt0_idx, gnt1_idx;
    logic                starve_any, rd_any, wr_grant;
    logic [WARP_W-1:0]   sel_warp;
    logic [LANE_W-1:0]   data0, data1;

    for (genvar g = 0; g < N; g++) begin : g_req
        assign req[g]     = {rd_warp[g*WARP_W +: WARP_W], rd_addr[g*ADDR_W +: ADDR_W],
                             rd_mask[g*LANE_W +: LANE_W]};
        assign starved[g] = rd_valid[g] && (wait_cnt[g] == LIMIT);
    end

    // First starved and first valid requester in round-robin order drive the warp choice.
    always_comb begin
        starve_any = 1'b0;
        starve_idx = '0;
        rd_any     = 1'b0;
        first_idx  = '0;
        scan_idx   = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr) + k) % N);
            if (starved[scan_idx] && !starve_any) begin
                starve_any = 1'b1;
                starve_idx = scan_idx;
            end
            if (rd_valid[scan_idx] && !rd_any) begin
                rd_any    = 1'b1;
                first_idx = scan_idx;
            end
        end
    end

    always_comb begin
        wr_grant = 1'b0;
        sel_warp = issue.warp;
        if (starve_any) begin
            sel_warp = req[starve_idx].warp;
            wr_grant = wr_valid && (wr_warp == sel_warp);
        end else if (wr_valid) begin
            sel_warp = wr_warp;
            wr_grant = 1'b1;
        end else if (rd_any) begin
            sel_warp = req[first_idx].warp;
        end
    end

    always_comb begin
        clash = '0;
        elig  = '0;
        for (int i = 0; i < N; i++) begin
`ifdef PRED_SCHED_FWD_EN
            clash[i] = 1'b0;
`else
            clash[i] = wr_grant && (req[i].addr == wr_addr);
`endif
            elig[i] = rd_valid[i] && (req[i].warp == sel_warp) && !clash[i];
        end
    end

    pred_rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
        .req    (elig),
        .ptr    (rr_ptr),
        .first  (gnt_first),
        .second (gnt_second)
    );

    assign rd_grant = gnt_first | gnt_second;
    assign rd_ready = rst_n ? rd_grant : '0;
    assign wr_ready = rst_n && wr_grant;

    always_comb begin
        gnt0_idx = '0;
        gnt1_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_first[i])  gnt0_idx = PTR_W'(i);
            if (gnt_second[i]) gnt1_idx = PTR_W'(i);
        end
        rr_ptr_d = rr_ptr;
        if (gnt_second != '0)
            rr_ptr_d = PTR_W'((int'(gnt1_idx) + 1) % N);
        else if (gnt_first != '0)
            rr_ptr_d = PTR_W'((int'(gnt0_idx) + 1) % N);
    end

    // Idle cycles keep the warp selector but clear every enable.
    always_comb begin
        issue_d      = '0;
        issue_d.warp = issue.warp;
        if (wr_grant || (rd_grant != '0))
            issue_d.warp = sel_warp;
        if (wr_grant) begin
            issue_d.we    = wr_mask;
            issue_d.waddr = wr_addr;
            issue_d.wdata = wr_data;
        end
        if (gnt_first != '0) begin
            issue_d.v0  = 1'b1;
            issue_d.re0 = req[gnt0_idx].mask;
            issue_d.ra0 = req[gnt0_idx].addr;
            issue_d.id0 = ID_W'(gnt0_idx);
        end
        if (gnt_second != '0) begin
            issue_d.v1  = 1'b1;
            issue_d.re1 = req[gnt1_idx].mask;
            issue_d.ra1 = req[gnt1_idx].addr;
            issue_d.id1 = ID_W'(gnt1_idx);
        end
    end

    assign pr_warp_selector = issue.warp;
    assign pr_write_en      = issue.we;
    assign pr_waddr         = issue.waddr;
    assign pr_wdata         = issue.wdata;
    assign pr_read_en_0     = issue.re0;
    assign pr_read_en_1     = issue.re1;
    assign pr_raddr_0       = issue.ra0;
    assign pr_raddr_1       = issue.ra1;

    // The block reads combinationally, so response data is captured at the end of the issue cycle.
    always_comb begin
        data0 = pr_rdata_0;
        data1 = pr_rdata_1;
`ifdef PRED_SCHED_FWD_EN
        if (issue.ra0 == issue.waddr)
            data0 = (issue.wdata & issue.we) | (pr_rdata_0 & ~issue.we);
        if (issue.ra1 == issue.waddr)
            data1 = (issue.wdata & issue.we) | (pr_rdata_1 & ~issue.we);
`else
        data0 = pr_rdata_0;
        data1 = pr_rdata_1;
`endif
        data0 = data0 & issue.re0;
        data1 = data1 & issue.re1;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        for (int i = 0; i < N; i++) begin
            if (issue.v0 && (issue.id0 == ID_W'(i))) begin
                rsp_valid_d[i]               = 1'b1;
                rsp_data_d[i*LANE_W +: LANE_W] = data0;
            end
            if (issue.v1 && (issue.id1 == ID_W'(i))) begin
                rsp_valid_d[i]               = 1'b1;
                rsp_data_d[i*LANE_W +: LANE_W] = data1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue     <= '0;
            rr_ptr    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int i = 0; i < N; i++)
                wait_cnt[i] <= '0;
        end else begin
            issue     <= issue_d;
            rr_ptr    <= rr_ptr_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            for (int i = 0; i < N; i++) begin
                if (!rd_valid[i] || rd_grant[i])
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != LIMIT)
                    wait_cnt[i] <= wait_cnt[i] + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_pred_port_scheduler.sv
// Scoreboard bench for pred_port_scheduler with a behavioural predicate register block.
// Expected ready patterns for the same-address case follow PRED_SCHED_FWD_EN.
module tb_pred_port_scheduler;
    import pred_sched_pkg::*;

    localparam int N     = 4;
    localparam int LIMIT = 7;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wr_valid, wr_ready;
    logic [3:0]     wr_warp;
    logic [4:0]     wr_addr;
    logic [7:0]     wr_mask, wr_data;
    logic [N-1:0]   rd_valid, rd_ready, rsp_valid;
    logic [N*4-1:0] rd_warp;
    logic [N*5-1:0] rd_addr;
    logic [N*8-1:0] rd_mask, rsp_data;
    logic [3:0]     pr_warp_selector;
    logic [7:0]     pr_write_en, pr_wdata, pr_read_en_0, pr_read_en_1, pr_rdata_0, pr_rdata_1;
    logic [4:0]     pr_waddr, pr_raddr_0, pr_raddr_1;

    pred_port_scheduler #(.NUM_RD_REQ(N), .STARVE_LIMIT(LIMIT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_warp          (wr_warp),
        .wr_addr          (wr_addr),
        .wr_mask          (wr_mask),
        .wr_data          (wr_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_warp          (rd_warp),
        .rd_addr          (rd_addr),
        .rd_mask          (rd_mask),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .pr_warp_selector (pr_warp_selector),
        .pr_write_en      (pr_write_en),
        .pr_waddr         (pr_waddr),
        .pr_wdata         (pr_wdata),
        .pr_read_en_0     (pr_read_en_0),
        .pr_read_en_1     (pr_read_en_1),
        .pr_raddr_0       (pr_raddr_0),
        .pr_raddr_1       (pr_raddr_1),
        .pr_rdata_0       (pr_rdata_0),
        .pr_rdata_1       (pr_rdata_1)
    );

    always #5 clk = ~clk;

    // Predicate register block: per-lane write at the clock edge, combinational read.
    logic [7:0] mem [16][32];
    always @(posedge clk) begin
        for (int l = 0; l < 8; l++)
            if (pr_write_en[l]) mem[pr_warp_selector][pr_waddr][l] <= pr_wdata[l];
    end
    assign pr_rdata_0 = mem[pr_warp_selector][pr_raddr_0] & pr_read_en_0;
    assign pr_rdata_1 = mem[pr_warp_selector][pr_raddr_1] & pr_read_en_1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb [$];
    exp_t       head;
    logic [7:0] exp_rsp [N];
    int         checks   = 0;
    int         failures = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL rsp unexpected: requester %0d data %0h with nothing expected",
                                 i, rsp_data[i*8 +: 8]);
                    end else begin
                        head = sb.pop_front();
                        check_output("rsp id", i, head.id);
                        check_output("rsp data", rsp_data[i*8 +: 8], head.data);
                        check_output("rsp latency", cyc, head.due);
                    end
                end
            end
        end
    end

    task automatic clear_inputs();
        wr_valid = 1'b0;
        wr_warp  = '0;
        wr_addr  = '0;
        wr_mask  = '0;
        wr_data  = '0;
        rd_valid = '0;
        rd_warp  = '0;
        rd_addr  = '0;
        rd_mask  = '0;
    endtask

    task automatic set_write(input logic [3:0] w, input logic [4:0] a, input logic [7:0] m,
                             input logic [7:0] d);
        wr_valid = 1'b1;
        wr_warp  = w;
        wr_addr  = a;
        wr_mask  = m;
        wr_data  = d;
    endtask

    task automatic set_read(input int i, input logic [3:0] w, input logic [4:0] a,
                            input logic [7:0] m, input logic [7:0] expect_data);
        rd_valid[i]        = 1'b1;
        rd_warp[i*4 +: 4]  = w;
        rd_addr[i*5 +: 5]  = a;
        rd_mask[i*8 +: 8]  = m;
        exp_rsp[i]         = expect_data;
    endtask

    // Called just after a falling edge with inputs set; checks readies, queues responses, runs one edge.
    task automatic apply_stimulus(input logic exp_wr, input logic [N-1:0] exp_rd, input string name);
        logic [N-1:0] rd_taken;
        logic         wr_taken;
        #1;
        check_output({name, " wr_ready"}, 32'(wr_ready), 32'(exp_wr));
        check_output({name, " rd_ready"}, 32'(rd_ready), 32'(exp_rd));
        for (int i = 0; i < N; i++)
            if (exp_rd[i]) sb.push_back('{i, exp_rsp[i], cyc + 2});
        rd_taken = rd_ready & rd_valid;
        wr_taken = wr_ready & wr_valid;
        @(posedge clk);
        #1;
        rd_valid = rd_valid & ~rd_taken;
        if (wr_taken) wr_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        repeat (3) @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int   waited;
        logic got;

        clear_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset held with every request asserted.
        set_write(4'd3, 5'd1, 8'hFF, 8'h12);
        for (int i = 0; i < N; i++) set_read(i, 4'd3, 5'(i), 8'hFF, 8'h00);
        repeat (3) begin
            @(negedge clk);
            check_output("reset wr_ready", 32'(wr_ready), 32'd0);
            check_output("reset rd_ready", 32'(rd_ready), 32'd0);
            check_output("reset rsp_valid", 32'(rsp_valid), 32'd0);
            check_output("reset pr bus", {pr_write_en, pr_read_en_0, pr_read_en_1, pr_warp_selector},
                         32'd0);
        end
        clear_inputs();
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] write then read back");
        set_write(4'd3, 5'd5, 8'hFF, 8'hA5);
        apply_stimulus(1'b1, 4'b0000, "t2 write");
        set_read(0, 4'd3, 5'd5, 8'hFF, 8'hA5);
        apply_stimulus(1'b0, 4'b0001, "t2 read");
        reset_dut();

        $display("[TB] three reads on one warp");
        set_write(4'd2, 5'd1, 8'hFF, 8'h11);
        apply_stimulus(1'b1, 4'b0000, "t3 write1");
        set_write(4'd2, 5'd2, 8'hFF, 8'h22);
        apply_stimulus(1'b1, 4'b0000, "t3 write2");
        set_write(4'd2, 5'd3, 8'hFF, 8'h33);
        apply_stimulus(1'b1, 4'b0000, "t3 write3");
        set_read(0, 4'd2, 5'd1, 8'hFF, 8'h11);
        set_read(1, 4'd2, 5'd2, 8'hFF, 8'h22);
        set_read(2, 4'd2, 5'd3, 8'hFF, 8'h33);
        apply_stimulus(1'b0, 4'b0011, "t3 pair");
        check_output("t3 rr_ptr after pair", 32'(dut.rr_ptr), 32'd2);
        apply_stimulus(1'b0, 4'b0100, "t3 third");
        check_output("t3 rr_ptr after third", 32'(dut.rr_ptr), 32'd3);
        reset_dut();

        $display("[TB] starvation against a constant writer");
        set_write(4'd7, 5'd3, 8'hFF, 8'h5A);
        apply_stimulus(1'b1, 4'b0000, "t4 preload");
        set_write(4'd1, 5'd2, 8'hFF, 8'h3C);
        set_read(3, 4'd7, 5'd3, 8'hFF, 8'h5A);
        waited = 0;
        got    = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (rd_ready[3]) begin
                got = 1'b1;
                check_output("t4 wr_ready at starved grant", 32'(wr_ready), 32'd0);
                sb.push_back('{3, exp_rsp[3], cyc + 2});
            end else begin
                waited++;
                check_output("t4 wr_ready while read waits", 32'(wr_ready), 32'd1);
            end
            @(posedge clk);
            #1;
            if (got) rd_valid[3] = 1'b0;
            @(negedge clk);
        end
        check_output("t4 waiting cycles", waited, LIMIT);
        clear_inputs();
        reset_dut();

        $display("[TB] write and read to the same register");
        set_write(4'd0, 5'd9, 8'hFF, 8'h00);
        apply_stimulus(1'b1, 4'b0000, "t5 clear");
        set_write(4'd0, 5'd9, 8'h0F, 8'hFF);
        set_read(0, 4'd0, 5'd9, 8'hFF, 8'h0F);
`ifdef PRED_SCHED_FWD_EN
        apply_stimulus(1'b1, 4'b0001, "t5 forwarded read");
`else
        apply_stimulus(1'b1, 4'b0000, "t5 write first");
        apply_stimulus(1'b0, 4'b0001, "t5 deferred read");
`endif
        reset_dut();

        $display("[TB] masked read and reset mid-flight");
        set_write(4'd4, 5'd10, 8'hFF, 8'hFF);
        apply_stimulus(1'b1, 4'b0000, "t6 write");
        set_read(1, 4'd4, 5'd10, 8'h81, 8'h81);
        apply_stimulus(1'b0, 4'b0010, "t6 masked read");
        repeat (3) @(negedge clk);

        set_read(2, 4'd4, 5'd10, 8'hFF, 8'hFF);
        apply_stimulus(1'b0, 4'b0100, "t6 read before reset");
        @(negedge clk);
        #1;
        check_output("t6 rsp_valid before reset", 32'(rsp_valid), 32'b0100);
        rst_n = 1'b0;
        #1;
        check_output("t6 rsp_valid drops on reset", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        set_read(3, 4'd4, 5'd10, 8'hFF, 8'hFF);
        #1;
        check_output("t6 in-flight rd_ready", 32'(rd_ready), 32'b1000);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check_output("t6 issue cleared", 32'({pr_read_en_0, pr_read_en_1}), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check_output("t6 no rsp after reset", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;

        repeat (4) @(negedge clk);
        check_output("scoreboard drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
